// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed scan controller that feeds one shared
//   bcd2seven decoder across NUM_DIGITS digit positions, using a double-buffered display word.
// Latency: the outputs are registered and aligned with the scan state. dig_en
//   lights one cycle after en is seen, and a new word appears at idx 0 of the next frame.
// Backpressure: there is none. load is a fire-and-forget strobe. A word loaded
//   mid-frame waits in the shadow register, and a later load overwrites it.
//
// Ports:
//   clk, rst      system clock and synchronous active-high reset
//   en            1 = scan the digits, 0 = idle with all digits off
//   load          single-cycle strobe that captures digits_in
//   digits_in     packed BCD word; nibble k drives digit k (digit 0 is rightmost)
//   bcd_out       nibble presented to the shared decoder
//   dig_en        one-hot active-high digit enable
//   blank         the current slot is suppressed (dig_en forced to 0)
//   pending       a shadow word is waiting for the frame boundary
//   frame_done    one-cycle pulse on the final cycle of the last digit
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Digit 0 is never blanked for being zero, so an all-zero word shows a single "0".

module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    blank,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Scan state
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  // Registered outputs
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    blank_q, blank_d;
  logic                    frame_done_q, frame_done_d;

  // Helpers for decoding the outputs
  logic [3:0]              nib_d;
  logic                    lz_blank_d;

  // Next-state logic: the scan sequencer plus the double-buffer commit rules.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pre_d     = pre_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SCAN;
          idx_d   = '0;
          pre_d   = '0;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        pre_d   = '0;
      end
    endcase

    // frame_done_q already reflects the current cycle, because the outputs are
    // registered from next-state values. That makes it the frame-boundary qualifier.
    if (load) begin
      if (state_q != SCAN || frame_done_q) begin
        // When idle, or exactly on the boundary, the new word goes straight to
        // the active register. Any stale shadow word is dropped.
        active_d  = digits_in;
        pending_d = 1'b0;
      end else begin
        shadow_d  = digits_in;
        pending_d = 1'b1;
      end
    end else if (frame_done_q && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Output decode. The outputs are computed from next-state values so that the
  // registered outputs line up with the registered scan state in the same cycle.
  always_comb begin
    nib_d = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_d = active_d[4*k +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit. zero_run stays set while every nibble seen
  // so far is zero. Digit 0 is excluded so that a lone zero still shows.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_d = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && (active_d[4*k +: 4] == 4'd0);
      if (idx_d == IDX_W'(k)) begin
        lz_blank_d = zero_run;
      end
    end
  end
`else
  always_comb begin
    lz_blank_d = 1'b0;
  end
`endif

  always_comb begin
    bcd_d        = 4'd0;
    dig_en_d     = '0;
    blank_d      = 1'b0;
    frame_done_d = 1'b0;
    if (state_d == SCAN) begin
      // The raw nibble still goes out even when blanked.
      bcd_d   = nib_d;
      blank_d = (nib_d > 4'd9) || lz_blank_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_en_d[k] = !blank_d && (idx_d == IDX_W'(k));
      end
      frame_done_d = (idx_d == IDX_LAST) && (pre_d == PRE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pre_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= 4'd0;
      dig_en_q     <= '0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pre_q        <= pre_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      dig_en_q     <= dig_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign dig_en     = dig_en_q;
  assign blank      = blank_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one bcd2seven decoder across NUM_DIGITS common-anode/cathode digit positions. Holds a double-buffered BCD display word and cycles a one-hot digit enable, presenting one BCD nibble per slot to the shared decoder. New display words are committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (>=2)
REFRESH_DIV, 1000, clock cycles each digit stays enabled (>=2); prescaler width = $clog2(REFRESH_DIV)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = scan, 0 = all digits off (IDLE)
load  input  1  single-cycle strobe; capture digits_in
digits_in  input  4*NUM_DIGITS  packed BCD; nibble k = digits_in[4k+3:4k], digit 0 = least significant/rightmost
bcd_out  output  4  nibble for the shared decoder (A,B,C,D = bcd_out[3:0])
dig_en  output  NUM_DIGITS  one-hot active-high digit enable
blank  output  1  current slot suppressed (dig_en forced 0)
pending  output  1  shadow word waiting for commit
frame_done  output  1  one-cycle pulse on last digit's final cycle

Behaviour:
- Registers: state {IDLE, SCAN}, idx (digit index), pre (prescaler), active word, shadow word, pending.
- Outputs are Moore: decoded from registers only, no combinational input-to-output path.
- Reset (rst=1 at edge): state=IDLE, idx=0, pre=0, active=0, shadow=0, pending=0. Outputs: bcd_out=0, dig_en=0, blank=0, pending=0, frame_done=0. Reset wins over all other inputs, including mid-frame.
- IDLE: dig_en=0, bcd_out=0, blank=0. If en=1 at edge: SCAN, idx=0, pre=0. dig_en=one-hot(0) in the following cycle.
- SCAN: bcd_out=active nibble[idx]; dig_en=one-hot(idx) unless blank. pre increments every cycle. At pre=REFRESH_DIV-1: pre<=0, idx<=idx+1, wrapping NUM_DIGITS-1 -> 0. Each digit is enabled exactly REFRESH_DIV cycles.
- frame_done=1 while state=SCAN, idx=NUM_DIGITS-1 and pre=REFRESH_DIV-1.
- en=0 in SCAN: next edge -> IDLE, idx=0, pre=0. Shadow and pending are retained.
- Blanking: nibble > 9 (A-F) -> blank=1, dig_en=0 for that slot. bcd_out still carries the raw nibble. Slot timing is unchanged.
- Load/commit rules:
  - load in IDLE: active<=digits_in directly, pending<=0.
  - load in SCAN, not at frame_done: shadow<=digits_in, pending<=1. Repeated loads overwrite; latest wins.
  - frame_done with pending=1 and no load: active<=shadow, pending<=0.
  - load coincident with frame_done: active<=digits_in, pending<=0; stale shadow discarded.
  - New active word first appears at idx=0 of the next frame.

Optional Feature:
LEADING_ZERO_BLANK_EN. Defined: in SCAN, a slot k>0 is also blanked when active nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never zero-blanked, so 0000 shows a single "0". Undefined: zeros always display; blank asserts only for nibbles > 9.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset/enable: rst 2 cycles, en=0, load digits_in=16'h1234 -> dig_en=0. Then en=1 -> dig_en sequence 0001,0010,0100,1000, each 4 cycles; bcd_out 4,3,2,1; frame_done pulses once per 16 cycles.
- Anti-tear: mid-frame (idx=1) load 16'h5678 -> pending=1, remainder of frame still 3,2,1. Next frame shows 8,7,6,5; pending=0 after the frame_done edge.
- Load coincident with frame_done: shadow holds 16'h1111, load 16'h9999 at frame_done -> next frame all 9, pending=0.
- Invalid BCD: active 16'h1A23 -> slot 2 blank=1, dig_en=0000 for 4 cycles, bcd_out=A; other slots normal.
- en drop and rst mid-frame: en=0 at idx=2 -> IDLE next cycle, dig_en=0, pending retained; re-enable restarts at idx=0. rst at idx=3 -> all outputs reset values next cycle.
- LEADING_ZERO_BLANK_EN: active 16'h0050 -> slots 3,2 blanked, slots 1,0 show 5,0. 16'h0000 -> only slot 0 lit. Macro undefined -> all four slots lit.
